// File: rtl/ttni_gw_pkg.sv
// ttni_gw_pkg: shared gateway types, the default word width and the miss-flag bit positions.
// Contents:
//   GW_WORD_W  - default channel word width
//   pair_t     - aligned pair {a, b, miss_a, miss_b}
//   MISS_*_BIT - miss-flag positions within the low two bits of a packed pair_t
package ttni_gw_pkg;
  localparam int GW_WORD_W = 32;
  localparam int MISS_A_BIT = 1;
  localparam int MISS_B_BIT = 0;
  typedef struct packed {
    logic [GW_WORD_W-1:0] a;
    logic [GW_WORD_W-1:0] b;
    logic                 miss_a;
    logic                 miss_b;
  } pair_t;
endpackage

// File: rtl/gw_word_fifo.sv
// gw_word_fifo: single-clock DEPTH-entry word FIFO that drops pushes arriving while it is full.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push, din   - write strobe and word
//   pop         - remove head (ignored when empty)
//   head        - oldest word, valid when !empty
//   empty, full - occupancy status
//   drop        - push rejected this cycle (full and no pop)
module gw_word_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full,
  output logic         drop
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;
  always_comb begin
    empty   = cnt_q == '0;
    full    = cnt_q == CW'(DEPTH);
    do_pop  = pop & !empty;
    // a pop frees a slot in the same cycle, so a push on a full FIFO is still taken
    do_push = push & (!full | do_pop);
    drop    = push & full & !do_pop;
    head    = mem_q[rd_q];
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;
endmodule

// File: rtl/dual_chan_align.sv
// dual_chan_align: buffers words from two redundant receive channels and emits them as registered aligned pairs, timing out lone words.
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   a_valid/a_data, b_valid/b_data - channel word strobes and data
//   out_valid/out_ready         - pair handshake
//   out_a/out_b                 - pair words (0 on the missing side)
//   miss_a/miss_b               - pair was emitted by timeout without that side
//   ovf_a/ovf_b                 - sticky FIFO-overflow drop flags
module dual_chan_align
  import ttni_gw_pkg::*;
#(
  parameter int WORD_W  = GW_WORD_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [WORD_W-1:0] a_data,
  input  logic              b_valid,
  input  logic [WORD_W-1:0] b_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_a,
  output logic [WORD_W-1:0] out_b,
  output logic              miss_a,
  output logic              miss_b,
  output logic              ovf_a,
  output logic              ovf_b
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  logic [WORD_W-1:0] head_a, head_b;
  logic              emp_a, emp_b, ne_a, ne_b, pop_a, pop_b, drop_a, drop_b;
  logic              unused_full_a, unused_full_b;
  logic              load_ok, lone, tmo;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
  logic [1:0]        miss_q, miss_d;
  logic              ovf_a_q, ovf_a_d, ovf_b_q, ovf_b_d;
  gw_word_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_fifo_a (
    .clk(clk), .rst_n(rst_n), .push(a_valid), .din(a_data), .pop(pop_a),
    .head(head_a), .empty(emp_a), .full(unused_full_a), .drop(drop_a)
  );
  gw_word_fifo #(.W(WORD_W), .DEPTH(DEPTH)) u_fifo_b (
    .clk(clk), .rst_n(rst_n), .push(b_valid), .din(b_data), .pop(pop_b),
    .head(head_b), .empty(emp_b), .full(unused_full_b), .drop(drop_b)
  );
  always_comb begin
    ne_a        = !emp_a;
    ne_b        = !emp_b;
    load_ok     = !out_valid_q | out_ready;
    lone        = ne_a ^ ne_b;
    tmo         = lone & (tmr_q == T_LAST);
    pop_a       = 1'b0;
    pop_b       = 1'b0;
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    miss_d      = miss_q;
    if (load_ok) begin
      if (ne_a & ne_b) begin
        pop_a       = 1'b1;
        pop_b       = 1'b1;
        out_valid_d = 1'b1;
        out_a_d     = head_a;
        out_b_d     = head_b;
        miss_d      = '0;
      end else if (tmo) begin
        pop_a              = ne_a;
        pop_b              = ne_b;
        out_valid_d        = 1'b1;
        out_a_d            = ne_a ? head_a : '0;
        out_b_d            = ne_b ? head_b : '0;
        miss_d[MISS_A_BIT] = !ne_a;
        miss_d[MISS_B_BIT] = !ne_b;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
        miss_d      = '0;
      end
    end
    // the timer holds at its last value while the output register is blocked
    tmr_d   = (!lone || (tmo && load_ok)) ? '0 : (tmr_q == T_LAST) ? tmr_q : tmr_q + TW'(1);
    ovf_a_d = ovf_a_q | drop_a;
    ovf_b_d = ovf_b_q | drop_b;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tmr_q       <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      miss_q      <= '0;
      ovf_a_q     <= 1'b0;
      ovf_b_q     <= 1'b0;
    end else begin
      tmr_q       <= tmr_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      miss_q      <= miss_d;
      ovf_a_q     <= ovf_a_d;
      ovf_b_q     <= ovf_b_d;
    end
  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign miss_a    = miss_q[MISS_A_BIT];
  assign miss_b    = miss_q[MISS_B_BIT];
  assign ovf_a     = ovf_a_q;
  assign ovf_b     = ovf_b_q;
endmodule
